buzzer_arbiter: RTL and testbench

//  Owns the single piezo buzzer output of the keypad lock and arbitrates it between three

---
 rtl/buzzer_arbiter.sv | 138 +++++++++++++
 tb/tb_buzzer_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/buzzer_arbiter.sv
// Fixed-priority buzzer arbiter for the keypad lock: latches request pulses,
// picks err > ok > key, and plays a square-wave tone pattern for a set length.
module buzzer_arbiter #(
  parameter int unsigned KEY_HALF = 50000,
  parameter int unsigned KEY_LEN  = 10000000,
  parameter int unsigned OK_HALF  = 25000,
  parameter int unsigned OK_LEN   = 30000000,
  parameter int unsigned ERR_HALF = 100000,
  parameter int unsigned ERR_GAP0 = 5000000,
  parameter int unsigned ERR_GAP1 = 10000000,
  parameter int unsigned ERR_LEN  = 15000000,
  parameter int unsigned CW       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_key,
  input  logic       req_ok,
  input  logic       req_err,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  localparam logic [CW-1:0] KEY_HALF_M1 = CW'(KEY_HALF - 1);
  localparam logic [CW-1:0] OK_HALF_M1  = CW'(OK_HALF - 1);
  localparam logic [CW-1:0] ERR_HALF_M1 = CW'(ERR_HALF - 1);
  localparam logic [CW-1:0] KEY_LEN_M1  = CW'(KEY_LEN - 1);
  localparam logic [CW-1:0] OK_LEN_M1   = CW'(OK_LEN - 1);
  localparam logic [CW-1:0] ERR_LEN_M1  = CW'(ERR_LEN - 1);
  localparam logic [CW-1:0] GAP_LO      = CW'(ERR_GAP0);
  localparam logic [CW-1:0] GAP_HI      = CW'(ERR_GAP1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  logic [0:0]    state_q, state_d;
  logic [1:0]    id_q, id_d;
  logic [CW-1:0] dur_q, dur_d;
  logic [CW-1:0] half_q, half_d;
  logic          tone_q, tone_d;
  logic          buzzer_q, buzzer_d;
  logic          done_q, done_d;
  logic [1:0]    req_id;
  logic          last, start, gap_d;

  function automatic logic [CW-1:0] len_m1(input logic [1:0] id);
    case (id)
      2'd1:    len_m1 = KEY_LEN_M1;
      2'd2:    len_m1 = OK_LEN_M1;
      2'd3:    len_m1 = ERR_LEN_M1;
      default: len_m1 = '0;
    endcase
  endfunction

  function automatic logic [CW-1:0] half_m1(input logic [1:0] id);
    case (id)
      2'd1:    half_m1 = KEY_HALF_M1;
      2'd2:    half_m1 = OK_HALF_M1;
      2'd3:    half_m1 = ERR_HALF_M1;
      default: half_m1 = '0;
    endcase
  endfunction

  always_comb begin
    req_id = 2'd0;
    if (req_err)      req_id = 2'd3;
    else if (req_ok)  req_id = 2'd2;
    else if (req_key) req_id = 2'd1;

    last  = (state_q == S_PLAY) && (dur_q == len_m1(id_q));
    // The ending pattern no longer blocks anything, so any request restarts on its last cycle.
    start = (req_id != 2'd0) && ((state_q == S_IDLE) || last || (req_id >= id_q));

    state_d = state_q;
    id_d    = id_q;
    dur_d   = dur_q;
    half_d  = half_q;
    tone_d  = tone_q;

    if (start) begin
      state_d = S_PLAY;
      id_d    = req_id;
      dur_d   = '0;
      half_d  = '0;
      tone_d  = 1'b1;
    end else if (state_q == S_PLAY) begin
      if (last) begin
        state_d = S_IDLE;
        id_d    = 2'd0;
        dur_d   = '0;
        half_d  = '0;
        tone_d  = 1'b0;
      end else begin
        dur_d = dur_q + CNT_ONE;
        if (half_q == half_m1(id_q)) begin
          half_d = '0;
          tone_d = ~tone_q;
        end else begin
          half_d = half_q + CNT_ONE;
        end
      end
    end

    // Outputs are computed from next state so they line up with the counters they describe.
    gap_d    = (id_d == 2'd3) && (dur_d >= GAP_LO) && (dur_d < GAP_HI);
    done_d   = (state_d == S_PLAY) && (dur_d == len_m1(id_d));
    buzzer_d = (state_d == S_PLAY) && tone_d && !mute && !gap_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      id_q     <= 2'd0;
      dur_q    <= '0;
      half_q   <= '0;
      tone_q   <= 1'b0;
      buzzer_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      dur_q    <= dur_d;
      half_q   <= half_d;
      tone_q   <= tone_d;
      buzzer_q <= buzzer_d;
      done_q   <= done_d;
    end
  end

  assign buzzer    = buzzer_q;
  assign busy      = (state_q == S_PLAY);
  assign active_id = id_q;
  assign done      = done_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench for buzzer_arbiter: directed pattern checks plus
// random traffic compared every cycle against a pattern-level model.
module tb_buzzer_arbiter;

  localparam int KH = 2, KL = 10, OH = 1, OL = 8, EH = 3, G0 = 6, G1 = 12, EL = 18;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_key = 1'b0, req_ok = 1'b0, req_err = 1'b0, mute = 1'b0;
  logic       buzzer, busy, done;
  logic [1:0] active_id;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  buzzer_arbiter #(
    .KEY_HALF(KH), .KEY_LEN(KL), .OK_HALF(OH), .OK_LEN(OL),
    .ERR_HALF(EH), .ERR_GAP0(G0), .ERR_GAP1(G1), .ERR_LEN(EL), .CW(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_key(req_key), .req_ok(req_ok),
    .req_err(req_err), .mute(mute), .buzzer(buzzer), .busy(busy),
    .active_id(active_id), .done(done)
  );

  always #5 clk = ~clk;

  // Pattern-level model: which pattern plays, how long it has played, mute seen at the edge.
  bit m_play = 1'b0;
  int m_id   = 0;
  int m_el   = 0;
  bit m_mute = 1'b0;

  function automatic int m_len(input int id);
    return (id == 1) ? KL : (id == 2) ? OL : EL;
  endfunction

  function automatic int m_half(input int id);
    return (id == 1) ? KH : (id == 2) ? OH : EH;
  endfunction

  always @(posedge clk) begin
    int  rid;
    bit  ending;
    if (!rst_n) begin
      m_play = 1'b0; m_id = 0; m_el = 0;
    end else begin
      rid    = req_err ? 3 : req_ok ? 2 : req_key ? 1 : 0;
      ending = m_play && (m_el == m_len(m_id) - 1);
      if (rid != 0 && (!m_play || ending || rid >= m_id)) begin
        m_play = 1'b1; m_id = rid; m_el = 0;
      end else if (m_play) begin
        if (ending) begin
          m_play = 1'b0; m_id = 0; m_el = 0;
        end else begin
          m_el++;
        end
      end
    end
    m_mute = mute;
  end

  always @(negedge clk) begin
    logic       e_buz, e_busy, e_done;
    logic [1:0] e_id;
    if (chk_en) begin
      e_busy = m_play;
      e_id   = 2'(m_id);
      e_done = m_play && (m_el == m_len(m_id) - 1);
      e_buz  = m_play && !m_mute && (((m_el / m_half(m_id)) % 2) == 0)
               && !(m_id == 3 && m_el >= G0 && m_el < G1);
      total++;
      if (buzzer !== e_buz || busy !== e_busy || active_id !== e_id || done !== e_done) begin
        bad++;
        $display("FAIL model t=%0t act buz=%b busy=%b id=%0d done=%b exp buz=%b busy=%b id=%0d done=%b",
                 $time, buzzer, busy, active_id, done, e_buz, e_busy, e_id, e_done);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // One-cycle request pulse; returns just after the edge that samples it (start of cycle 1).
  task automatic pulse(input logic k, input logic o, input logic e);
    @(posedge clk); #1;
    req_key = k; req_ok = o; req_err = e;
    @(posedge clk); #1;
    req_key = 1'b0; req_ok = 1'b0; req_err = 1'b0;
    $display("req key=%b ok=%b err=%b at t=%0t", k, o, e, $time);
  endtask

  initial begin
    logic [9:0] key_wave;
    logic [7:0] ok_wave;
    int         drops;
    key_wave = 10'b1100110011;
    ok_wave  = 8'b10101010;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_buz", buzzer, 0);
    chk("reset_busy", busy, 0);
    chk("reset_id", active_id, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Key pattern: exact waveform and done position.
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("key_buz", buzzer, key_wave[9 - i]);
      chk("key_id", active_id, 1);
      chk("key_done", done, (i == 9) ? 1 : 0);
    end
    @(negedge clk);
    chk("key_idle", busy, 0);

    // Key and ok together: ok wins, toggles each cycle, no key pattern afterwards.
    pulse(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ok_buz", buzzer, ok_wave[7 - i]);
      chk("ok_id", active_id, 2);
    end
    @(negedge clk);
    chk("ok_no_key", busy, 0);

    // Err preempts key at cycle 4 and restarts high.
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 req_err = 1'b1;
    @(posedge clk); #1 req_err = 1'b0;
    @(negedge clk);
    chk("err_pre_id", active_id, 3);
    chk("err_pre_buz", buzzer, 1);
    repeat (20) @(posedge clk);

    // Retrigger ok on its done cycle: busy must never drop.
    pulse(1'b0, 1'b1, 1'b0);
    repeat (OL - 1) @(posedge clk);
    #1 req_ok = 1'b1;
    @(posedge clk); #1 req_ok = 1'b0;
    drops = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!busy) drops++;
    end
    chk("ok_retrig_busy_drops", drops, 0);
    repeat (10) @(posedge clk);

    // Muted key pattern: silent but same sequencing.
    @(posedge clk); #1 mute = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mute_buz", buzzer, 0);
      chk("mute_done", done, (i == 9) ? 1 : 0);
    end
    @(posedge clk); #1 mute = 1'b0;

    // Reset mid-pattern.
    pulse(1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_id", active_id, 0);
    chk("rst_mid_buz", buzzer, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      req_key = ($urandom_range(7) == 0);
      req_ok  = ($urandom_range(19) == 0);
      req_err = ($urandom_range(29) == 0);
      if ($urandom_range(49) == 0) mute = ~mute;
      rst_n = ($urandom_range(499) != 0);
    end
    @(posedge clk); #1;
    req_key = 1'b0; req_ok = 1'b0; req_err = 1'b0; rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
